// File: rtl/oam_sprite_search_pkg.sv
// Shared types for the mode-2 OAM sprite search: line-buffer entry layout, FSM states
// and the hit arithmetic used by the scanner.
package oam_sprite_search_pkg;

    localparam int NUM_SPRITES      = 40;
    localparam int MAX_LINE_SPRITES = 10;
    localparam int OAM_ADDR_W       = 8;

    typedef enum logic {
        SPRITE_8  = 1'b0,
        SPRITE_16 = 1'b1
    } sprite_size_e;

    typedef struct packed {
        logic [5:0] oam_index;
        logic [7:0] x;
        logic [3:0] row;
    } line_sprite_t;

    typedef line_sprite_t line_sprite_buf_t [0:MAX_LINE_SPRITES-1];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } oam_search_state_e;

    function automatic logic [8:0] sprite_height(input logic size);
        return (size == SPRITE_16) ? 9'd16 : 9'd8;
    endfunction

    // OAM Y is biased by 16; a borrow wraps to a large value so sprites below ly+16 never hit.
    function automatic logic [8:0] hit_diff(input logic [7:0] ly, input logic [7:0] y);
        return {1'b0, ly} + 9'd16 - {1'b0, y};
    endfunction

endpackage

// File: rtl/oam_sprite_search_if.sv
// OAM RAM read port: the scanner (master) presents address and read strobe; the RAM
// (slave) returns {YPosition, XPosition} on the cycle after the strobe.
interface oam_sprite_search_if;
    import oam_sprite_search_pkg::*;

    logic [OAM_ADDR_W-1:0] oam_addr;
    logic                  oam_rd;
    logic [15:0]           oam_rdata;

    modport master (
        output oam_addr,
        output oam_rd,
        input  oam_rdata
    );

    modport slave (
        input  oam_addr,
        input  oam_rd,
        output oam_rdata
    );

endinterface

// File: rtl/oam_sprite_search_sprite_line_buffer.sv
// Per-line selected-sprite buffer with count, sticky overflow and combinational read port.
// OAM_SEARCH_XSORT_EN: insertion-sort hits by ascending X; otherwise append in OAM order.
module oam_sprite_search_sprite_line_buffer
    import oam_sprite_search_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_en,
    input  line_sprite_t wr_entry,
    output logic [3:0]   count,
    output logic         overflow,
    input  logic [3:0]   rd_idx,
    output line_sprite_t rd_entry
);

    line_sprite_buf_t buf_q, buf_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
`ifdef OAM_SEARCH_XSORT_EN
    logic [3:0]       pos;
`endif

    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        ovf_d   = ovf_q;
`ifdef OAM_SEARCH_XSORT_EN
        pos     = '0;
`endif
        if (clear) begin
            for (int i = 0; i < MAX_LINE_SPRITES; i++) buf_d[i] = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (wr_en) begin
            if (count_q == 4'(MAX_LINE_SPRITES)) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
`ifdef OAM_SEARCH_XSORT_EN
                // Equal X counts as "before" so the lower OAM index (already stored) stays first.
                for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
                    if (4'(i) < count_q && buf_q[i].x <= wr_entry.x) pos = pos + 4'd1;
                end
                for (int i = 1; i < MAX_LINE_SPRITES; i++) begin
                    if (4'(i) > pos && 4'(i) <= count_q) buf_d[i] = buf_q[i-1];
                end
                for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
                    if (4'(i) == pos) buf_d[i] = wr_entry;
                end
`else
                for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
                    if (4'(i) == count_q) buf_d[i] = wr_entry;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LINE_SPRITES; i++) buf_q[i] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        rd_entry = '0;
        for (int i = 0; i < MAX_LINE_SPRITES; i++) begin
            if (4'(i) == rd_idx) rd_entry = buf_q[i];
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/oam_sprite_search.sv
// PPU mode-2 OAM scan: two cycles per entry (FETCH strobes OAM, CHECK evaluates the hit),
// selected sprites go to the line buffer. Optional X sorting via OAM_SEARCH_XSORT_EN.
module oam_sprite_search
    import oam_sprite_search_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           ly,
    input  logic                 sprite_size,
    oam_sprite_search_if.master  oam,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           sprite_count,
    output logic                 overflow,
    input  logic [3:0]           rd_idx,
    output logic [5:0]           rd_oam_idx,
    output logic [7:0]           rd_x,
    output logic [3:0]           rd_row,
    output oam_search_state_e    state
);

    oam_search_state_e state_q, state_d;
    logic [5:0]        idx_q;
    logic [7:0]        ly_q;
    logic              size_q;
    logic              accept;
    logic [8:0]        diff;
    logic              hit;
    line_sprite_t      hit_entry;
    line_sprite_t      rd_entry;

    // Valid/ready contract: start is a one-cycle request accepted only in IDLE;
    // done is a one-cycle completion pulse, after which the buffer holds until the next accept.
    assign accept = (state_q == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ly_q    <= '0;
            size_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ly_q   <= ly;
                size_q <= sprite_size;
                idx_q  <= '0;
            end else if (state_q == CHECK) begin
                idx_q <= idx_q + 6'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = CHECK;
            CHECK:   state_d = (idx_q < 6'(NUM_SPRITES - 1)) ? FETCH : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign oam.oam_addr = {idx_q, 2'b00};
    assign oam.oam_rd   = (state_q == FETCH);

    assign diff = hit_diff(ly_q, oam.oam_rdata[15:8]);
    assign hit  = (state_q == CHECK) && (diff < sprite_height(size_q));

    assign hit_entry.oam_index = idx_q;
    assign hit_entry.x         = oam.oam_rdata[7:0];
    assign hit_entry.row       = diff[3:0];

    oam_sprite_search_sprite_line_buffer u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .wr_en    (hit),
        .wr_entry (hit_entry),
        .count    (sprite_count),
        .overflow (overflow),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry)
    );

    assign rd_oam_idx = rd_entry.oam_index;
    assign rd_x       = rd_entry.x;
    assign rd_row     = rd_entry.row;

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign state = state_q;

endmodule
